// File: rtl/skew_engine.sv
`default_nettype none
// ============================================================================
// Module   : skew_engine
// Purpose  : N-lane systolic skew / deskew delay engine. Each lane carries an
//            N-deep {valid, data} shift register that advances on accepted
//            beats and on DRAIN cycles. In skew mode lane i is delayed i+1
//            steps; in deskew mode lane i is delayed N-i steps. Job framing
//            markers (first/last) travel with lane 0 / lane N-1 respectively.
// Ports    : clk, rst_n            - clock, async active-low reset
//            mode                  - 0 skew, 1 deskew (latched on job start)
//            in_valid / in_ready   - input handshake
//            data_in               - N packed lanes, lane i at [(i+1)*W-1 -: W]
//            first_in / last_in    - job framing markers
//            data_out              - delayed lanes, same packing
//            out_valid_row         - per-lane valid pulse on each advance
//            first_out / last_out  - markers aligned with lane 0 / lane N-1
//            busy                  - engine not IDLE
//            drain_done            - pulse when a job fully drains
//            protocol_err          - pulse on a framing violation
// Revision : 1.0 - initial release
// ============================================================================
module skew_engine #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] data_in,
    input  logic                    first_in,
    input  logic                    last_in,
    output logic [N*DATA_WIDTH-1:0] data_out,
    output logic [N-1:0]            out_valid_row,
    output logic                    first_out,
    output logic                    last_out,
    output logic                    busy,
    output logic                    drain_done,
    output logic                    protocol_err
);

    localparam int              c_CW        = $clog2(N + 1);
    localparam logic [1:0]      c_ST_IDLE   = 2'd0;
    localparam logic [1:0]      c_ST_STREAM = 2'd1;
    localparam logic [1:0]      c_ST_DRAIN  = 2'd2;
    localparam logic [c_CW-1:0] c_DRAIN_LEN = c_CW'(N);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nx;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nx;
    logic            r_mode;
    logic            w_mode;
    logic            r_in_ready;
    logic            r_busy;
    logic            r_drain_done;
    logic            r_protocol_err;
    logic            r_first_out;
    logic            r_last_out;
    logic [N-1:0]    r_first_sr;
    logic [N-1:0]    r_last_sr;
    logic [N-1:0]    w_first_nx;
    logic [N-1:0]    w_last_nx;
    logic            w_accept;
    logic            w_idle;
    logic            w_start;
    logic            w_drop;
    logic            w_push;
    logic            w_advance;
    logic            w_perr;
    logic            w_done;
    logic            w_first_tap;
    logic            w_last_tap;

    // ------------------------------------------------------------------------
    // Handshake and advance qualification
    // ------------------------------------------------------------------------
    assign w_accept  = in_valid && r_in_ready;
    assign w_idle    = (r_state == c_ST_IDLE);
    assign w_start   = w_accept && w_idle && first_in;
    // A beat arriving in IDLE without a job-start marker is discarded entirely:
    // it neither enters the lanes nor advances them.
    assign w_drop    = w_accept && w_idle && !first_in;
    assign w_push    = w_accept && !w_drop;
    assign w_advance = w_push || (r_state == c_ST_DRAIN);
    assign w_perr    = w_drop || (w_accept && (r_state == c_ST_STREAM) && first_in);

    // The starting beat must already use the new job's mode for its taps,
    // since the output registers are loaded from next-state stage values.
    assign w_mode    = w_start ? mode : r_mode;

    // ------------------------------------------------------------------------
    // Control FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_done     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    if (last_in) begin
                        w_state_nx = c_ST_DRAIN;
                        w_cnt_nx   = c_DRAIN_LEN;
                    end else begin
                        w_state_nx = c_ST_STREAM;
                    end
                end
            end
            c_ST_STREAM: begin
                if (w_accept && last_in) begin
                    w_state_nx = c_ST_DRAIN;
                    w_cnt_nx   = c_DRAIN_LEN;
                end
            end
            c_ST_DRAIN: begin
                if (r_cnt == c_ONE) begin
                    w_state_nx = c_ST_IDLE;
                    w_done     = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - c_ONE;
                end
            end
            default: w_state_nx = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Marker pipelines: first follows lane 0, last follows lane N-1
    // ------------------------------------------------------------------------
    assign w_first_nx  = w_advance ? {r_first_sr[N-2:0], w_start}           : r_first_sr;
    assign w_last_nx   = w_advance ? {r_last_sr[N-2:0], w_push && last_in}  : r_last_sr;
    assign w_first_tap = w_mode ? w_first_nx[N-1] : w_first_nx[0];
    assign w_last_tap  = w_mode ? w_last_nx[0]    : w_last_nx[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_ST_IDLE;
            r_cnt          <= '0;
            r_mode         <= 1'b0;
            r_in_ready     <= 1'b1;
            r_busy         <= 1'b0;
            r_drain_done   <= 1'b0;
            r_protocol_err <= 1'b0;
            r_first_sr     <= '0;
            r_last_sr      <= '0;
            r_first_out    <= 1'b0;
            r_last_out     <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_cnt          <= w_cnt_nx;
            if (w_start) begin
                r_mode <= mode;
            end
            r_in_ready     <= (w_state_nx != c_ST_DRAIN);
            r_busy         <= (w_state_nx != c_ST_IDLE);
            r_drain_done   <= w_done;
            r_protocol_err <= w_perr;
            r_first_sr     <= w_first_nx;
            r_last_sr      <= w_last_nx;
            r_first_out    <= w_advance && w_first_tap;
            r_last_out     <= w_advance && w_last_tap;
        end
    end

    // ------------------------------------------------------------------------
    // Per-lane delay lines. Stage index k holds the datum that has seen k+1
    // advance steps, so skew lane i taps index i and deskew lane i taps N-1-i.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam int c_SKEW_TAP   = gi;
        localparam int c_DESKEW_TAP = N - 1 - gi;

        logic [N-1:0]          r_vld;
        logic [N-1:0]          w_vld_nx;
        logic [DATA_WIDTH-1:0] r_dat    [N];
        logic [DATA_WIDTH-1:0] w_dat_nx [N];
        logic                  w_tap_vld;
        logic [DATA_WIDTH-1:0] w_tap_dat;
        logic                  r_out_vld;
        logic [DATA_WIDTH-1:0] r_out_dat;

        always_comb begin
            w_vld_nx = r_vld;
            for (int k = 0; k < N; k++) begin
                w_dat_nx[k] = r_dat[k];
            end
            if (w_advance) begin
                w_vld_nx    = {r_vld[N-2:0], w_push};
                w_dat_nx[0] = w_push ? data_in[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH] : '0;
                for (int k = 1; k < N; k++) begin
                    w_dat_nx[k] = r_dat[k-1];
                end
            end
        end

        assign w_tap_vld = w_mode ? w_vld_nx[c_DESKEW_TAP] : w_vld_nx[c_SKEW_TAP];
        assign w_tap_dat = w_mode ? w_dat_nx[c_DESKEW_TAP] : w_dat_nx[c_SKEW_TAP];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld     <= '0;
                r_out_vld <= 1'b0;
                r_out_dat <= '0;
                for (int k = 0; k < N; k++) begin
                    r_dat[k] <= '0;
                end
            end else begin
                r_vld <= w_vld_nx;
                for (int k = 0; k < N; k++) begin
                    r_dat[k] <= w_dat_nx[k];
                end
                // On a stall the tap is unchanged, so data holds while the
                // valid pulse drops.
                r_out_vld <= w_tap_vld && w_advance;
                r_out_dat <= w_tap_vld ? w_tap_dat : '0;
            end
        end

        assign data_out[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH] = r_out_dat;
        assign out_valid_row[gi]                          = r_out_vld;
    end

    assign in_ready     = r_in_ready;
    assign busy         = r_busy;
    assign drain_done   = r_drain_done;
    assign protocol_err = r_protocol_err;
    assign first_out    = r_first_out;
    assign last_out     = r_last_out;

endmodule
`default_nettype wire

// File: tb/tb_skew_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_skew_engine
// Purpose  : Self-checking bench for skew_engine (N=4, DATA_WIDTH=8). Each
//            job precomputes the cycle of every advance step, pushes expected
//            lane outputs / marker pulses into scoreboard queues, and a
//            monitor pops and compares them as the engine produces output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skew_engine;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk           = 1'b0;
    logic          rst_n         = 1'b0;
    logic          mode          = 1'b0;
    logic          in_valid      = 1'b0;
    logic          first_in      = 1'b0;
    logic          last_in       = 1'b0;
    logic [N*DW-1:0] data_in     = '0;
    logic          in_ready;
    logic [N*DW-1:0] data_out;
    logic [N-1:0]  out_valid_row;
    logic          first_out;
    logic          last_out;
    logic          busy;
    logic          drain_done;
    logic          protocol_err;

    skew_engine #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode          (mode),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_in       (data_in),
        .first_in      (first_in),
        .last_in       (last_in),
        .data_out      (data_out),
        .out_valid_row (out_valid_row),
        .first_out     (first_out),
        .last_out      (last_out),
        .busy          (busy),
        .drain_done    (drain_done),
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; outputs sampled at a negedge were
    // produced by edge number cyc.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          lane;
        logic [DW-1:0] d;
        int          c;
    } exp_t;

    exp_t            q_dat[$];
    int              q_first[$];
    int              q_last[$];
    int              q_done[$];
    int              q_perr[$];
    logic [N*DW-1:0] beats[$];
    logic [DW-1:0]   last_exp [N];
    int              checks = 0;
    int              errors = 0;
    bit              mon_en = 1'b0;

    // ------------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------------
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int i = 0; i < N; i++) begin
                    if (out_valid_row[i]) begin
                        int idx = -1;
                        for (int j = 0; j < q_dat.size(); j++)
                            if (idx < 0 && q_dat[j].lane == i) idx = j;
                        checks++;
                        if (idx < 0) begin
                            errors++;
                            $display("FAIL lane%0d_unexpected cyc=%0d got %h required no valid", i, cyc, data_out[i*DW +: DW]);
                        end else begin
                            exp_t e = q_dat[idx];
                            q_dat.delete(idx);
                            if (data_out[i*DW +: DW] !== e.d || cyc != e.c) begin
                                errors++;
                                $display("FAIL lane%0d_data got %h at cyc %0d required %h at cyc %0d", i, data_out[i*DW +: DW], cyc, e.d, e.c);
                            end
                            last_exp[i] = e.d;
                        end
                    end
                end
                if (first_out) begin
                    checks++;
                    if (q_first.size() == 0) begin
                        errors++;
                        $display("FAIL first_out_unexpected cyc=%0d", cyc);
                    end else begin
                        int c = q_first.pop_front();
                        if (c != cyc) begin
                            errors++;
                            $display("FAIL first_out_timing got cyc %0d required cyc %0d", cyc, c);
                        end
                    end
                end
                if (last_out) begin
                    checks++;
                    if (q_last.size() == 0) begin
                        errors++;
                        $display("FAIL last_out_unexpected cyc=%0d", cyc);
                    end else begin
                        int c = q_last.pop_front();
                        if (c != cyc) begin
                            errors++;
                            $display("FAIL last_out_timing got cyc %0d required cyc %0d", cyc, c);
                        end
                    end
                end
                if (drain_done) begin
                    checks++;
                    if (q_done.size() == 0) begin
                        errors++;
                        $display("FAIL drain_done_unexpected cyc=%0d", cyc);
                    end else begin
                        int c = q_done.pop_front();
                        if (c != cyc) begin
                            errors++;
                            $display("FAIL drain_done_timing got cyc %0d required cyc %0d", cyc, c);
                        end
                    end
                end
                if (protocol_err) begin
                    checks++;
                    if (q_perr.size() == 0) begin
                        errors++;
                        $display("FAIL protocol_err_unexpected cyc=%0d", cyc);
                    end else begin
                        int c = q_perr.pop_front();
                        if (c != cyc) begin
                            errors++;
                            $display("FAIL protocol_err_timing got cyc %0d required cyc %0d", cyc, c);
                        end
                    end
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Generic job: drives the beats queued in 'beats', optionally stalling
    // stall_len cycles after beat stall_at. Must be entered on a negedge.
    // ------------------------------------------------------------------------
    task automatic run_job(input bit md, input int stall_at, input int stall_len, input string name);
        int adv[$];
        int c;
        int nb;
        int d;
        logic [N*DW-1:0] hold;
        nb = beats.size();
        c  = cyc + 1;
        for (int b = 0; b < nb; b++) begin
            if (stall_at >= 0 && b == stall_at + 1) c += stall_len;
            adv.push_back(c);
            c++;
        end
        for (int k = 0; k < N; k++) begin
            adv.push_back(c);
            c++;
        end
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < N; i++) begin
                d = md ? (N - i) : (i + 1);
                q_dat.push_back('{lane: i, d: beats[b][i*DW +: DW], c: adv[b + d - 1]});
            end
        end
        q_first.push_back(adv[md ? (N - 1) : 0]);
        q_last.push_back(adv[nb - 1 + (md ? 0 : (N - 1))]);
        q_done.push_back(adv[nb - 1 + N]);

        for (int b = 0; b < nb; b++) begin
            if (stall_at >= 0 && b == stall_at + 1) begin
                in_valid = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    for (int i = 0; i < N; i++) hold[i*DW +: DW] = last_exp[i];
                    checks++;
                    if (out_valid_row !== '0 || data_out !== hold) begin
                        errors++;
                        $display("FAIL %s_stall_hold valid=%b data=%h required valid=0 data=%h", name, out_valid_row, data_out, hold);
                    end
                end
            end
            // Mode is only meaningful on the starting beat; flip it elsewhere.
            mode     = (b == 0) ? md : ~md;
            in_valid = 1'b1;
            first_in = (b == 0);
            last_in  = (b == nb - 1);
            data_in  = beats[b];
            @(negedge clk);
        end
        in_valid = 1'b0;
        first_in = 1'b0;
        last_in  = 1'b0;
        mode     = ~md;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_drain_flags in_ready=%b busy=%b required in_ready=0 busy=1", name, in_ready, busy);
        end
        repeat (N) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_flags in_ready=%b busy=%b required in_ready=1 busy=0", name, in_ready, busy);
        end
        checks++;
        if (q_dat.size() != 0 || q_first.size() != 0 || q_last.size() != 0 || q_done.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_outputs data=%0d first=%0d last=%0d done=%0d required all 0",
                     name, q_dat.size(), q_first.size(), q_last.size(), q_done.size());
        end
        q_dat.delete(); q_first.delete(); q_last.delete(); q_done.delete();
        beats.delete();
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({data_out, out_valid_row, first_out, last_out, busy, drain_done, protocol_err} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values data=%h valid=%b busy=%b ready=%b required zeros ready=1", data_out, out_valid_row, busy, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid_row !== '0) begin
            errors++;
            $display("FAIL reset_release busy=%b ready=%b valid=%b required 0/1/0", busy, in_ready, out_valid_row);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_idle_no_first();
        q_perr.push_back(cyc + 1);
        mode     = 1'b0;
        in_valid = 1'b1;
        first_in = 1'b0;
        last_in  = 1'b0;
        data_in  = 32'h5555_5555;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid_row !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_drop_flags valid=%b busy=%b ready=%b required 0/0/1", out_valid_row, busy, in_ready);
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (q_perr.size() != 0) begin
            errors++;
            $display("FAIL idle_drop_perr pending=%0d required 0", q_perr.size());
        end
        q_perr.delete();
        @(negedge clk);
    endtask

    task automatic test_skew();
        for (int k = 0; k < 4; k++)
            beats.push_back({8'(8'h10*k + 3), 8'(8'h10*k + 2), 8'(8'h10*k + 1), 8'(8'h10*k)});
        run_job(1'b0, -1, 0, "skew");
        @(negedge clk);
    endtask

    task automatic test_deskew();
        logic [N*DW-1:0] v;
        int vi;
        for (int b = 0; b < 7; b++) begin
            for (int i = 0; i < N; i++) begin
                vi = b - i;
                v[i*DW +: DW] = (vi >= 0 && vi < 4) ? 8'(8'h80 + 8'h10*vi + i) : 8'(8'hE0 + b);
            end
            beats.push_back(v);
        end
        run_job(1'b1, -1, 0, "deskew");
        @(negedge clk);
    endtask

    task automatic test_stall();
        for (int k = 0; k < 6; k++)
            beats.push_back({8'(8'h10*k + 3), 8'(8'h10*k + 2), 8'(8'h10*k + 1), 8'(8'h10*k)});
        run_job(1'b0, 3, 3, "stall");
        @(negedge clk);
    endtask

    task automatic test_single();
        beats.push_back(32'hA3A2_A1A0);
        run_job(1'b0, -1, 0, "single");
        @(negedge clk);
    endtask

    task automatic test_reset_drain();
        mon_en   = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b1;
        first_in = 1'b1;
        last_in  = 1'b1;
        data_in  = 32'hB3B2_B1B0;
        @(negedge clk);
        in_valid = 1'b0;
        first_in = 1'b0;
        last_in  = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstdrain_in_drain busy=%b ready=%b required 1/0", busy, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out, out_valid_row, first_out, last_out, busy, drain_done, protocol_err} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstdrain_async data=%h valid=%b busy=%b ready=%b required zeros ready=1", data_out, out_valid_row, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid_row !== '0 || last_out !== 1'b0 || drain_done !== 1'b0 || first_out !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstdrain_after valid=%b last=%b done=%b first=%b busy=%b required all 0",
                         out_valid_row, last_out, drain_done, first_out, busy);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) last_exp[i] = '0;
        fork
            monitor();
        join_none
        @(negedge clk);
        test_reset();
        test_idle_no_first();
        test_skew();
        test_deskew();
        test_stall();
        test_single();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
